ysyx_clint: RTL and testbench
=============================

Name: ysyx_clint

Overview:
Core-local timer (CLINT) slave exposing a free-running 64-bit mtime counter over an AXI4-style single-beat slave interface. Sits beside the system bus arbiter, which routes LSU loads that hit the RTC addresses here instead of to the external master port. The counter is read as two 32-bit words (low, high). Writes are accepted and answered but ignored unless the optional feature is compiled in.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; only 32 is supported
ADDR_LO, 32'h0200_0048, address of mtime[31:0]
ADDR_HI, 32'h0200_004C, address of mtime[63:32]

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
arburst  in  2  ignored
arsize  in  3  ignored
arlen  in  8  ignored; every response is a single beat
arid  in  4  read ID
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready_o  out  1  read address ready
rid  out  4  read response ID
rlast_o  out  1  last beat
rdata_o  out  DATA_W  read data
rresp_o  out  2  read response
rvalid_o  out  1  read data valid
rready  in  1  read data ready
awburst, awsize, awlen  in  2/3/8  ignored
awid  in  4  write ID
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready_o  out  1  write address ready
wlast  in  1  ignored
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wvalid  in  1  write data valid
wready_o  out  1  write data ready
bid  out  4  write response ID
bresp_o  out  2  write response
bvalid_o  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset values: mtime=0; rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=0, bresp_o=0, rid=0, bid=0; arready_o=1, awready_o=1, wready_o=1.
- mtime increments by 1 on every non-reset clock, including during accesses. It wraps from 2^64-1 to 0.
- Read path, states IDLE and RESP:
  - arready_o=1 only in IDLE. On arvalid&arready_o, the block moves to RESP on the next edge.
  - In RESP: rvalid_o=1, rlast_o=rvalid_o, rid=captured arid.
  - rdata_o holds the mtime value at the accept edge (pre-increment): [31:0] for ADDR_LO, [63:32] for ADDR_HI.
  - Any other address returns rdata_o=0 and rresp_o=2'b11 (DECERR). Valid addresses return rresp_o=2'b00.
  - RESP returns to IDLE on rvalid_o&rready. The next accept can occur at the earliest one cycle later, so latency is 1 cycle and throughput is 1 read per 2 cycles.
  - rdata_o is held stable while rvalid_o is high and rready is low.
- Write path:
  - AW and W are captured independently. awready_o drops once AW is held; wready_o drops once W is held. AW and W may arrive in the same cycle or in either order.
  - When both are held, bvalid_o rises on the next edge with bid=captured awid. Both holders clear on bvalid_o&bready, and awready_o/wready_o return to 1.
  - Without the optional feature: data is discarded, bresp_o=2'b10 (SLVERR).
- Read and write channels are fully independent. Simultaneous activity is allowed.
- Reset mid-transaction aborts the transaction and restores all reset values.

Optional Feature:
YSYX_CLINT_MTIME_WRITE_EN
- Defined:
  - A write to ADDR_LO or ADDR_HI updates the selected mtime word byte-wise per wstrb. The write commits on the edge where bvalid_o rises and takes precedence over the increment that cycle.
  - bresp_o=2'b00 for these addresses; other addresses get 2'b11.
  - A read accepted on the commit edge returns the pre-write value.
- Undefined: mtime is read-only and all writes get SLVERR.

Decomposition:
- Package ysyx_clint_pkg: response codes (OKAY, SLVERR, DECERR) and the read FSM state enum (IDLE, RESP).
- Address defaults stay as module parameters.
- One natural sub-module, ysyx_clint_mtime: the 64-bit counter with optional word/strobe write port.
- The AXI handshake logic stays in the top module.

Test Plan:
- Reset for 3 cycles, release, wait 10 cycles, read ADDR_LO with rready=1 -> rvalid_o one cycle after accept, rdata_o equals the cycle count since reset release (10 ± accept alignment), rresp_o=0, rlast_o=1.
- Force mtime near 32'hFFFF_FFFF via back-to-back LO/HI reads across the carry -> HI word increments by 1 exactly when the LO word wraps to 0.
- Read 32'h0200_0050 with arid=4'h5 -> rdata_o=0, rresp_o=2'b11, rid=4'h5.
- arvalid held high with rready=0 for 5 cycles -> rvalid_o stays 1, rdata_o stable, arready_o=0. Then rready=1 -> one handshake, arready_o=1 next cycle.
- Write ADDR_LO, AW two cycles before W, awid=4'h3 -> bvalid_o one cycle after W accept, bid=4'h3, bresp_o=2'b10 (feature off), mtime unaffected.
- Feature on: write wdata=32'h0000_1000, wstrb=4'hF to ADDR_LO -> subsequent LO read returns 32'h1000 plus the cycles elapsed; bresp_o=0.

Source files
------------

// File: rtl/ysyx_clint_pkg.sv
// Shared definitions for the core-local timer: AXI response codes and the
// read-channel state encoding.
package ysyx_clint_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ysyx_clint_mtime.sv
// Free-running 64-bit mtime counter with a 32-bit word / byte-strobe write
// port. A write replaces the selected bytes and suppresses that cycle's
// increment.
module ysyx_clint_mtime (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_nxt;

  // Next value: increment, or merge the strobed bytes into the chosen word.
  always_comb begin
    mtime_nxt = mtime_q + 64'd1;
    if (wr_en) begin
      mtime_nxt = mtime_q;
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          if (wr_hi) mtime_nxt[32 + 8*b +: 8] = wr_data[8*b +: 8];
          else       mtime_nxt[8*b +: 8]      = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Counter register; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) mtime_q <= '0;
    else     mtime_q <= mtime_nxt;
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_clint.sv
// CLINT slave: exposes mtime as two 32-bit words over a single-beat AXI4
// slave port. Build option YSYX_CLINT_MTIME_WRITE_EN makes mtime writable;
// without it every write is answered with SLVERR and discarded.
//
// Read FSM:
//   state | meaning
//   IDLE  | arready high, waiting for a read address
//   RESP  | rvalid high, holding captured data until rready
module ysyx_clint
  import ysyx_clint_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter logic [ADDR_W-1:0] ADDR_LO = 32'h0200_0048,
  parameter logic [ADDR_W-1:0] ADDR_HI = 32'h0200_004C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  input  logic [7:0]          arlen,
  input  logic [3:0]          arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready_o,
  output logic [3:0]          rid,
  output logic                rlast_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic [7:0]          awlen,
  input  logic [3:0]          awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready_o,
  input  logic                wlast,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready_o,
  output logic [3:0]          bid,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready
);

  // Burst/size/last fields carry no information for single-beat word access.
  logic unused_inputs;
  assign unused_inputs = ^{arburst, arsize, arlen, awburst, awsize, awlen, wlast};

  logic [63:0] mtime;

  // ---------------- read channel ----------------
  rd_state_e         rd_state, rd_state_nxt;
  logic [DATA_W-1:0] rdata_q, rd_sel_data;
  logic [1:0]        rresp_q, rd_sel_resp;
  logic [3:0]        rid_q;
  logic              ar_hs, r_hs;

  assign arready_o = (rd_state == IDLE);
  assign rvalid_o  = (rd_state == RESP);
  assign rlast_o   = rvalid_o;
  assign ar_hs     = arvalid && arready_o;
  assign r_hs      = rvalid_o && rready;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rid       = rid_q;

  // Address decode of the requested mtime word.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_resp = RESP_DECERR;
    if (araddr == ADDR_LO) begin
      rd_sel_data = mtime[31:0];
      rd_sel_resp = RESP_OKAY;
    end else if (araddr == ADDR_HI) begin
      rd_sel_data = mtime[63:32];
      rd_sel_resp = RESP_OKAY;
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      IDLE:    if (ar_hs) rd_state_nxt = RESP;
      RESP:    if (r_hs)  rd_state_nxt = IDLE;
      default: rd_state_nxt = IDLE;
    endcase
  end

  // Read state and response capture; data is the pre-increment value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) begin
        rdata_q <= rd_sel_data;
        rresp_q <= rd_sel_resp;
        rid_q   <= arid;
      end
    end
  end

  // ---------------- write channel ----------------
  logic                aw_held, w_held, bvalid_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [3:0]          awid_q, bid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          bresp_q, wr_resp;
  logic                aw_hs, w_hs, b_fire, b_hs;
  logic                wr_en, wr_hi;

  assign awready_o = !aw_held;
  assign wready_o  = !w_held;
  assign aw_hs     = awvalid && awready_o;
  assign w_hs      = wvalid && wready_o;
  assign b_fire    = aw_held && w_held && !bvalid_q;
  assign b_hs      = bvalid_q && bready;
  assign bvalid_o  = bvalid_q;
  assign bid       = bid_q;
  assign bresp_o   = bresp_q;
  assign wr_hi     = (awaddr_q == ADDR_HI);

`ifdef YSYX_CLINT_MTIME_WRITE_EN
  logic wr_hit;
  assign wr_hit  = (awaddr_q == ADDR_LO) || wr_hi;
  assign wr_resp = wr_hit ? RESP_OKAY : RESP_DECERR;
  // Commit coincides with the response being raised.
  assign wr_en   = b_fire && wr_hit;
`else
  assign wr_resp = RESP_SLVERR;
  assign wr_en   = 1'b0;
`endif

  // AW/W holders fill independently; response fires once both are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      awaddr_q <= '0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
    end else if (b_hs) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
        awid_q   <= awid;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (b_fire) begin
        bvalid_q <= 1'b1;
        bid_q    <= awid_q;
        bresp_q  <= wr_resp;
      end
    end
  end

  ysyx_clint_mtime u_mtime (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_hi   (wr_hi),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q),
    .mtime   (mtime)
  );

endmodule

// File: tb/tb_ysyx_clint.sv
// Directed self-checking bench for ysyx_clint. Expected mtime comes from a
// bench-side edge counter plus a record of committed writes.
module tb_ysyx_clint;

  localparam logic [31:0] A_LO  = 32'h0200_0048;
  localparam logic [31:0] A_HI  = 32'h0200_004C;
  localparam logic [31:0] A_BAD = 32'h0200_0050;
`ifdef YSYX_CLINT_MTIME_WRITE_EN
  localparam logic [1:0] EXP_WR_OK  = 2'b00;
  localparam logic [1:0] EXP_WR_BAD = 2'b11;
`else
  localparam logic [1:0] EXP_WR_OK  = 2'b10;
  localparam logic [1:0] EXP_WR_BAD = 2'b10;
`endif

  logic        clk, rst;
  logic [1:0]  arburst, awburst;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata_o, wdata;
  logic        arvalid, arready_o, rlast_o, rvalid_o, rready;
  logic [1:0]  rresp_o, bresp_o;
  logic        awvalid, awready_o, wlast, wvalid, wready_o, bvalid_o, bready;
  logic [3:0]  wstrb;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] ecount, base, base_edge;
  logic [31:0] d, d2;
  logic [1:0]  r;
  logic [3:0]  i_r;
  logic [63:0] e, e2;

  ysyx_clint dut (
    .clk(clk), .rst(rst),
    .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid),
    .araddr(araddr), .arvalid(arvalid), .arready_o(arready_o),
    .rid(rid), .rlast_o(rlast_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid),
    .awaddr(awaddr), .awvalid(awvalid), .awready_o(awready_o),
    .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready_o(wready_o), .bid(bid), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
    .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of non-reset edges so far, i.e. expected mtime absent writes.
  always @(posedge clk) begin
    if (rst) ecount <= '0;
    else     ecount <= ecount + 64'd1;
  end

  function automatic logic [63:0] exp_mtime();
    return base + (ecount - base_edge);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model of a committed write, applied before the commit edge.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
`ifdef YSYX_CLINT_MTIME_WRITE_EN
    logic [63:0] m;
    m = exp_mtime();
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (addr == A_HI)      m[32 + 8*b +: 8] = data[8*b +: 8];
        else if (addr == A_LO) m[8*b +: 8]      = data[8*b +: 8];
      end
    end
    base      = m;
    base_edge = ecount + 64'd1;
`else
    if (addr == 32'hFFFF_FFFF && data == 32'hFFFF_FFFF && strb == 4'hF) base = base;
`endif
  endtask

  // Single read with rready already high; returns data and model expectation.
  task automatic rd(input logic [31:0] addr, input logic [3:0] id,
                    output logic [31:0] data, output logic [1:0] resp,
                    output logic [3:0] rid_s, output logic [63:0] expm);
    bit acc;
    acc = 1'b0;
    expm = '0;
    arvalid = 1'b1; araddr = addr; arid = id;
    for (int k = 0; k < 8 && !acc; k++) begin
      if (arready_o) begin
        expm = exp_mtime();
        acc = 1'b1;
      end
      tick();
    end
    arvalid = 1'b0;
    chk("rd_accept", acc, 1);
    chk("rd_rvalid", rvalid_o, 1);
    chk("rd_rlast", rlast_o, 1);
    data = rdata_o; resp = rresp_o; rid_s = rid;
    tick();
  endtask

  // Write with AW and W in the same cycle and bready high.
  task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    awvalid = 1'b1; awaddr = addr; awid = id;
    wvalid = 1'b1; wdata = data; wstrb = strb;
    bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_awready_drop", awready_o, 0);
    chk("wr_wready_drop", wready_o, 0);
    model_write(addr, data, strb);
    tick();
    chk("wr_bvalid", bvalid_o, 1);
    chk("wr_bid", bid, id);
    chk("wr_bresp", bresp_o, exp_resp);
    tick();
    chk("wr_bvalid_clr", bvalid_o, 0);
    chk("wr_awready_back", awready_o, 1);
    bready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arburst = '0; arsize = '0; arlen = '0; arid = '0; araddr = '0; arvalid = 1'b0;
    awburst = '0; awsize = '0; awlen = '0; awid = '0; awaddr = '0; awvalid = 1'b0;
    wlast = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    base = '0; base_edge = '0;
    repeat (3) tick();

    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rresp", rresp_o, 0);
    chk("rst_bresp", bresp_o, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_arready", arready_o, 1);
    chk("rst_awready", awready_o, 1);
    chk("rst_wready", wready_o, 1);
    chk("rst_rlast", rlast_o, 0);

    // First read after 10 cycles out of reset returns 10.
    rst = 1'b0;
    repeat (10) tick();
    rready = 1'b1;
    rd(A_LO, 4'h1, d, r, i_r, e);
    chk("first_lo_data", d, 32'd10);
    chk("first_lo_resp", r, 2'b00);
    chk("first_lo_rid", i_r, 4'h1);

    // Back-to-back LO/HI.
    rd(A_LO, 4'h2, d, r, i_r, e);
    chk("b2b_lo_data", d, e[31:0]);
    chk("b2b_lo_data_hand", d, 32'd12);
    rd(A_HI, 4'h3, d, r, i_r, e);
    chk("b2b_hi_data", d, 32'd0);
    chk("b2b_hi_resp", r, 2'b00);

    // Unmapped address.
    rd(A_BAD, 4'h5, d, r, i_r, e);
    chk("decerr_data", d, 0);
    chk("decerr_resp", r, 2'b11);
    chk("decerr_rid", i_r, 4'h5);

    // Back-pressure: arvalid held, rready low for 5 cycles.
    rready = 1'b0;
    arvalid = 1'b1; araddr = A_LO; arid = 4'h7;
    chk("stall_arready_pre", arready_o, 1);
    e = exp_mtime();
    tick();
    chk("stall_rvalid0", rvalid_o, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_rvalid", rvalid_o, 1);
      chk("stall_rdata", rdata_o, e[31:0]);
      chk("stall_arready", arready_o, 0);
    end
    chk("stall_rid", rid, 4'h7);
    rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("stall_rvalid_done", rvalid_o, 0);
    chk("stall_arready_back", arready_o, 1);
    tick();
    chk("stall_single_hs", rvalid_o, 0);

    // AW two cycles before W, bready held low for a cycle.
    awvalid = 1'b1; awaddr = A_LO; awid = 4'h3;
    tick();
    awvalid = 1'b0;
    chk("aw1_awready", awready_o, 0);
    chk("aw1_wready", wready_o, 1);
    tick();
    chk("aw1_no_b", bvalid_o, 0);
    wvalid = 1'b1; wdata = 32'h0000_1000; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    chk("aw1_wready_drop", wready_o, 0);
    chk("aw1_b_not_yet", bvalid_o, 0);
    model_write(A_LO, 32'h0000_1000, 4'hF);
    tick();
    chk("aw1_bvalid", bvalid_o, 1);
    chk("aw1_bid", bid, 4'h3);
    chk("aw1_bresp", bresp_o, EXP_WR_OK);
    tick();
    chk("aw1_bvalid_hold", bvalid_o, 1);
    bready = 1'b1;
    tick();
    chk("aw1_bvalid_clr", bvalid_o, 0);
    chk("aw1_awready_back", awready_o, 1);
    chk("aw1_wready_back", wready_o, 1);
    bready = 1'b0;
    rd(A_LO, 4'h4, d, r, i_r, e);
    chk("after_w1_lo", d, e[31:0]);
`ifndef YSYX_CLINT_MTIME_WRITE_EN
    chk("after_w1_lo_unaffected", d, ecount[31:0] - 32'd2);
`endif

    // AW and W together to HI.
    wr(A_HI, 4'h9, 32'h0000_0001, 4'hF, EXP_WR_OK);

    // W before AW, unmapped address.
    bready = 1'b1;
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready", wready_o, 0);
    chk("wfirst_awready", awready_o, 1);
    awvalid = 1'b1; awaddr = A_BAD; awid = 4'h4;
    tick();
    awvalid = 1'b0;
    tick();
    chk("wfirst_bvalid", bvalid_o, 1);
    chk("wfirst_bid", bid, 4'h4);
    chk("wfirst_bresp", bresp_o, EXP_WR_BAD);
    tick();
    chk("wfirst_bvalid_clr", bvalid_o, 0);
    bready = 1'b0;

    rd(A_LO, 4'h1, d, r, i_r, e);
    chk("post_w_lo", d, e[31:0]);
    rd(A_HI, 4'h1, d, r, i_r, e);
    chk("post_w_hi", d, e[63:32]);

`ifdef YSYX_CLINT_MTIME_WRITE_EN
    // Carry from LO into HI across the 32-bit wrap.
    wr(A_LO, 4'hA, 32'hFFFF_FFFC, 4'hF, 2'b00);
    rd(A_HI, 4'h1, d2, r, i_r, e2);
    chk("wrap_hi_before", d2, 32'h0000_0001);
    for (int k = 0; k < 3; k++) begin
      rd(A_LO, 4'h1, d, r, i_r, e);
      chk("wrap_lo", d, e[31:0]);
      rd(A_HI, 4'h1, d, r, i_r, e);
      chk("wrap_hi", d, e[63:32]);
    end
    chk("wrap_hi_after", d, 32'h0000_0002);
    wr(A_HI, 4'hB, 32'hAB00_0000, 4'h8, 2'b00);
    rd(A_HI, 4'h1, d, r, i_r, e);
    chk("strb_hi", d, 32'hAB00_0002);
`endif

    // Reset in the middle of a read and a write.
    rready = 1'b0;
    arvalid = 1'b1; araddr = A_LO; arid = 4'h6;
    tick();
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = A_LO; awid = 4'h2;
    tick();
    awvalid = 1'b0;
    chk("mid_rvalid", rvalid_o, 1);
    chk("mid_awready", awready_o, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", rvalid_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_rid", rid, 0);
    chk("mid_rst_arready", arready_o, 1);
    chk("mid_rst_awready", awready_o, 1);
    chk("mid_rst_bvalid", bvalid_o, 0);
    rst = 1'b0;
    base = '0; base_edge = '0;
    rready = 1'b1;
    repeat (4) tick();
    rd(A_LO, 4'h8, d, r, i_r, e);
    chk("post_rst_lo", d, 32'd4);
    rd(A_HI, 4'h8, d, r, i_r, e);
    chk("post_rst_hi", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
